// File: rtl/riscv_hazard_unit.sv
// Hazard and sequencing control for the 5-stage RV32I pipeline: E-stage forwarding,
// load-use bubbles, branch flushes, a data-memory wait FSM and debug event counters.
module riscv_hazard_unit #(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_rs1_d,
  input  logic [4:0]       i_rs2_d,
  input  logic [4:0]       i_rs1_e,
  input  logic [4:0]       i_rs2_e,
  input  logic [4:0]       i_rd_e,
  input  logic [1:0]       i_result_src_e,
  input  logic             i_pc_src_e,
  input  logic [4:0]       i_rd_m,
  input  logic             i_reg_write_m,
  input  logic             i_mem_req_m,
  input  logic [4:0]       i_rd_w,
  input  logic             i_reg_write_w,
  input  logic             i_cnt_clr,
  output logic [1:0]       o_fwd_a_e,
  output logic [1:0]       o_fwd_b_e,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_w,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_stall;
  logic               lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == rs)) begin
      return 2'b10;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    o_fwd_a_e = fwd_sel(i_rs1_e);
    o_fwd_b_e = fwd_sel(i_rs2_e);
  end

  // The release cycle (WAIT, cnt==0) deliberately ignores i_mem_req_m so the
  // same access instruction is not counted twice.
  always_comb begin
    mem_stall = ((state_q == RUN) && i_mem_req_m && (MEM_LAT != 0)) ||
                ((state_q == WAIT) && (cnt_q != '0));
    lw_stall  = (i_result_src_e == 2'b01) && (i_rd_e != 5'd0) &&
                ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
  end

  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_stall_m = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    o_flush_w = 1'b0;
    if (mem_stall) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_stall_e = 1'b1;
      o_stall_m = 1'b1;
      o_flush_w = 1'b1;
    end else if (i_pc_src_e) begin
      // The load-dependent instruction in D is discarded, so no stall is needed.
      o_flush_d = 1'b1;
      o_flush_e = 1'b1;
    end else if (lw_stall) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_flush_e = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (i_mem_req_m && (MEM_LAT != 0)) begin
        state_d = WAIT;
        cnt_d   = LAT_W'(MEM_LAT - 1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    if (i_cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      stall_cnt_d = stall_cnt_q + CNT_W'(o_stall_f);
      flush_cnt_d = flush_cnt_q + CNT_W'(o_flush_d);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Bench for riscv_hazard_unit: three instances (MEM_LAT 0, 3, 2) on shared inputs,
// checked against a cycle-indexed reference model, a vector table and directed sequences.
module tb_riscv_hazard_unit;
  localparam int CW = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic       pc_src_e, reg_write_m, mem_req_m, reg_write_w, cnt_clr;

  logic [1:0]    fwd_a [NI];
  logic [1:0]    fwd_b [NI];
  logic          stall_f [NI];
  logic          stall_d [NI];
  logic          stall_e [NI];
  logic          stall_m [NI];
  logic          flush_d [NI];
  logic          flush_e [NI];
  logic          flush_w [NI];
  logic [CW-1:0] scnt [NI];
  logic [CW-1:0] fcnt [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      riscv_hazard_unit #(
        .MEM_LAT((gi == 0) ? 0 : ((gi == 1) ? 3 : 2)),
        .CNT_W  (CW)
      ) u_dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_rs1_d       (rs1_d),
        .i_rs2_d       (rs2_d),
        .i_rs1_e       (rs1_e),
        .i_rs2_e       (rs2_e),
        .i_rd_e        (rd_e),
        .i_result_src_e(result_src_e),
        .i_pc_src_e    (pc_src_e),
        .i_rd_m        (rd_m),
        .i_reg_write_m (reg_write_m),
        .i_mem_req_m   (mem_req_m),
        .i_rd_w        (rd_w),
        .i_reg_write_w (reg_write_w),
        .i_cnt_clr     (cnt_clr),
        .o_fwd_a_e     (fwd_a[gi]),
        .o_fwd_b_e     (fwd_b[gi]),
        .o_stall_f     (stall_f[gi]),
        .o_stall_d     (stall_d[gi]),
        .o_stall_e     (stall_e[gi]),
        .o_stall_m     (stall_m[gi]),
        .o_flush_d     (flush_d[gi]),
        .o_flush_e     (flush_e[gi]),
        .o_flush_w     (flush_w[gi]),
        .o_stall_cnt   (scnt[gi]),
        .o_flush_cnt   (fcnt[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: an access occupies M from cycle acc_start to acc_start+L.
  int cyc;
  int acc_start [NI];
  int m_scnt [NI];
  int m_fcnt [NI];

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < NI; k++) begin
      acc_start[k] = -1;
      m_scnt[k]    = 0;
      m_fcnt[k]    = 0;
    end
  endtask

  // Called at the negedge of a cycle: compares all instances, then advances the model.
  task automatic eval_cycle();
    for (int k = 0; k < NI; k++) begin
      int   l;
      bit   in_acc, starts, ms, lw;
      logic sf, sd, se, sm, fd, fe, fw;
      logic [10:0] exp_v, act_v;
      l      = lat_of(k);
      in_acc = (acc_start[k] >= 0) && (cyc <= acc_start[k] + l);
      starts = !in_acc && mem_req_m && (l != 0);
      ms     = starts || (in_acc && cyc < acc_start[k] + l);
      lw     = (result_src_e == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
      {sf, sd, se, sm, fd, fe, fw} = '0;
      if (ms) {sf, sd, se, sm, fw} = '1;
      else if (pc_src_e) {fd, fe} = '1;
      else if (lw) {sf, sd, fe} = '1;
      exp_v = {ref_fwd(rs1_e), ref_fwd(rs2_e), sf, sd, se, sm, fd, fe, fw};
      act_v = {fwd_a[k], fwd_b[k], stall_f[k], stall_d[k], stall_e[k], stall_m[k],
               flush_d[k], flush_e[k], flush_w[k]};
      check($sformatf("outs_lat%0d", l), 32'(act_v), 32'(exp_v));
      check($sformatf("stall_cnt_lat%0d", l), 32'(scnt[k]), 32'(m_scnt[k]));
      check($sformatf("flush_cnt_lat%0d", l), 32'(fcnt[k]), 32'(m_fcnt[k]));
      if (k == 0)
        $display("cyc %0d: lat0 outs=%03h scnt=%0d fcnt=%0d", cyc, act_v, scnt[k], fcnt[k]);
      if (starts) acc_start[k] = cyc;
      if (cnt_clr) begin
        m_scnt[k] = 0;
        m_fcnt[k] = 0;
      end else begin
        m_scnt[k] = (m_scnt[k] + int'(sf)) % (1 << CW);
        m_fcnt[k] = (m_fcnt[k] + int'(fd)) % (1 << CW);
      end
    end
    cyc++;
  endtask

  task automatic finish_cycle();
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic clear_in();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    result_src_e = 2'b00;
    {pc_src_e, reg_write_m, mem_req_m, reg_write_w, cnt_clr} = '0;
  endtask

  typedef struct {
    logic [4:0] rs1_e, rd_m, rd_w, rd_e, rs2_d;
    logic       rwm, rww;
    logic [1:0] rsrc;
    logic       pc;
    logic [1:0] e_fwd_a;
    logic       e_sf, e_sd, e_fd, e_fe;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int s0;
    tbl[0] = '{5'd5, 5'd5, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{5'd5, 5'd5, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{5'd5, 5'd6, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    clear_in();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_stall_m", 32'(stall_m[k]), 32'd0);
      check("reset_stall_cnt", 32'(scnt[k]), 32'd0);
      check("reset_flush_cnt", 32'(fcnt[k]), 32'd0);
    end
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Vector table on the single-cycle-memory instance
    for (int i = 0; i < 8; i++) begin
      clear_in();
      rs1_e = tbl[i].rs1_e; rd_m = tbl[i].rd_m; rd_w = tbl[i].rd_w;
      rd_e = tbl[i].rd_e; rs2_d = tbl[i].rs2_d; reg_write_m = tbl[i].rwm;
      reg_write_w = tbl[i].rww; result_src_e = tbl[i].rsrc; pc_src_e = tbl[i].pc;
      @(negedge clk);
      check($sformatf("tbl%0d", i),
            32'({fwd_a[0], stall_f[0], stall_d[0], flush_d[0], flush_e[0]}),
            32'({tbl[i].e_fwd_a, tbl[i].e_sf, tbl[i].e_sd, tbl[i].e_fd, tbl[i].e_fe}));
      $display("vec %0d: fwd_a=%b sf=%b sd=%b fd=%b fe=%b", i, fwd_a[0], stall_f[0],
               stall_d[0], flush_d[0], flush_e[0]);
      finish_cycle();
    end
    clear_in();
    @(negedge clk);
    check("tbl_stall_cnt", 32'(scnt[0]), 32'd1);
    check("tbl_flush_cnt", 32'(fcnt[0]), 32'd1);
    finish_cycle();

    // MEM_LAT=3 single request: three stall cycles, then a release cycle
    s0 = int'(scnt[1]);
    mem_req_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat3_stall_m_c%0d", i), 32'(stall_m[1]), 32'(i < 3));
      check($sformatf("lat3_flush_w_c%0d", i), 32'(flush_w[1]), 32'(i < 3));
      $display("lat3 wait cycle %0d: stall_m=%b flush_w=%b", i, stall_m[1], flush_w[1]);
      finish_cycle();
      mem_req_m = 1'b0;
    end
    @(negedge clk);
    check("lat3_stall_cnt", 32'(scnt[1]), 32'((s0 + 3) % 256));
    finish_cycle();

    // Branch held in E across a MEM_LAT=2 wait takes effect on the release cycle
    pc_src_e  = 1'b1;
    mem_req_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        check($sformatf("lat2_flush_d_c%0d", i), 32'(flush_d[2]), 32'(i == 2));
        $display("lat2 branch cycle %0d: flush_d=%b", i, flush_d[2]);
      end
      finish_cycle();
      mem_req_m = 1'b0;
    end
    clear_in();
    cycle();

    // Asynchronous reset in the middle of a wait
    mem_req_m = 1'b1;
    cycle();
    mem_req_m = 1'b0;
    @(negedge clk);
    check("midwait_stall_m_before", 32'(stall_m[1]), 32'd1);
    rstn = 1'b0;
    #1;
    check("midwait_stall_m_lat3", 32'(stall_m[1]), 32'd0);
    check("midwait_stall_m_lat2", 32'(stall_m[2]), 32'd0);
    check("midwait_stall_cnt", 32'(scnt[1]), 32'd0);
    check("midwait_flush_cnt", 32'(fcnt[0]), 32'd0);
    $display("reset mid-wait: stall_m=%b scnt=%0d", stall_m[1], scnt[1]);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    mem_req_m = 1'b1;
    cycle();
    mem_req_m = 1'b0;
    repeat (4) cycle();

    // Counter clear wins over a simultaneous load-use increment
    result_src_e = 2'b01; rd_e = 5'd9; rs1_d = 5'd9;
    cycle();
    cnt_clr = 1'b1;
    cycle();
    clear_in();
    @(negedge clk);
    check("clr_vs_lwstall", 32'(scnt[0]), 32'd0);
    finish_cycle();

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_e  = 5'($urandom_range(0, 7)); rd_m  = 5'($urandom_range(0, 7));
      rd_w  = 5'($urandom_range(0, 7));
      result_src_e = 2'($urandom_range(0, 3));
      reg_write_m  = 1'($urandom_range(0, 1));
      reg_write_w  = 1'($urandom_range(0, 1));
      pc_src_e     = ($urandom_range(0, 5) == 0);
      mem_req_m    = ($urandom_range(0, 7) == 0);
      cnt_clr      = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_hazard_unit.md
Name: riscv_hazard_unit

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Resolves operand forwarding for the E stage and inserts load-use bubbles for the D stage.
- Flushes wrong-path instructions on taken branches and jumps.
- Freezes the whole pipeline for a configurable data-memory latency; exports stall and flush event counters for debug.

Parameters:
MEM_LAT, 0, extra cycles a data-memory access occupies M (0 = single-cycle memory, wait FSM never leaves RUN)
CNT_W, 32, width of the performance counters

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_rs1_d  in  5  rs1 field of instruction in D
i_rs2_d  in  5  rs2 field of instruction in D
i_rs1_e  in  5  rs1 of instruction in E
i_rs2_e  in  5  rs2 of instruction in E
i_rd_e  in  5  rd of instruction in E
i_result_src_e  in  2  result source in E (2'b01 = load)
i_pc_src_e  in  1  taken branch/jump/jalr resolved in E
i_rd_m  in  5  rd in M
i_reg_write_m  in  1  register write enable in M
i_mem_req_m  in  1  load or store in M
i_rd_w  in  5  rd in W
i_reg_write_w  in  1  register write enable in W
i_cnt_clr  in  1  synchronous clear of both counters
o_fwd_a_e  out  2  ALU operand A select: 00 regfile, 01 result_w, 10 alu_result_m
o_fwd_b_e  out  2  ALU operand B select, same encoding
o_stall_f  out  1  hold PC
o_stall_d  out  1  hold F/D register
o_stall_e  out  1  hold D/E register
o_stall_m  out  1  hold E/M register
o_flush_d  out  1  clear F/D register
o_flush_e  out  1  clear D/E register
o_flush_w  out  1  clear M/W register (bubble into W)
o_stall_cnt  out  CNT_W  cycles with o_stall_f=1
o_flush_cnt  out  CNT_W  cycles with o_flush_d=1

Behaviour:
- Forwarding (combinational), computed per operand with rsX_e:
  - 10 if reg_write_m && rd_m!=0 && rd_m==rsX_e.
  - Otherwise 01 if reg_write_w && rd_w!=0 && rd_w==rsX_e.
  - Otherwise 00.
  - M has priority over W.
  - Forward selects are independent of the FSM state.
- Wait FSM states:
  - RUN to WAIT when i_mem_req_m && MEM_LAT!=0; cnt <= MEM_LAT-1.
  - WAIT with cnt!=0: cnt decrements.
  - WAIT with cnt==0: release cycle, no mem stall, back to RUN.
- mem_stall = (RUN && i_mem_req_m && MEM_LAT!=0) || (WAIT && cnt!=0).
  - Total mem-stall cycles per access = MEM_LAT.
  - The access instruction occupies M for MEM_LAT+1 cycles.
  - The release cycle never retriggers on the same instruction.
- While mem_stall=1:
  - stall_f/d/e/m=1 and flush_w=1.
  - flush_d/flush_e forced 0; load-use is subsumed.
  - A pending i_pc_src_e stays held in E and takes effect on the release cycle.
- Load-use, when mem_stall=0:
  - lwstall = result_src_e==2'b01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
  - Then stall_f=stall_d=1, flush_e=1.
- Branch, when mem_stall=0 and i_pc_src_e=1:
  - flush_d=1, flush_e=1.
  - Takes priority over lwstall: stall_f/stall_d=0, because the dependent D instruction is discarded.
- Otherwise all stall/flush outputs are 0.
- Counters:
  - Increment by 1 per qualifying cycle and wrap at 2^CNT_W.
  - i_cnt_clr has priority over increment.
- Reset (async assert, sync-deasserted externally):
  - state=RUN, cnt=0, both counters 0.
  - Combinational outputs are evaluated as in RUN.
- Reset mid-WAIT aborts the wait immediately: stall_m drops in the same cycle.

Test Plan:
- Forwarding:
  - rs1_e=5, rd_m=5 with reg_write_m=1, rd_w=5 with reg_write_w=1 -> fwd_a_e=10.
  - Then reg_write_m=0 -> fwd_a_e=01.
  - rd_m=rd_w=0 with writes enabled -> 00.
- Load-use: result_src_e=01, rd_e=7, rs2_d=7 -> one cycle stall_f=stall_d=flush_e=1, stall_cnt +1; with rd_e=0 -> no stall.
- Branch vs load-use: same hazard plus pc_src_e=1 -> flush_d=flush_e=1, stall_f=0, flush_cnt +1.
- Memory wait, MEM_LAT=3: mem_req_m pulse -> stall_m=flush_w=1 for exactly 3 cycles, 4th cycle release with all stalls 0, stall_cnt=3.
- Branch during WAIT, MEM_LAT=2: pc_src_e=1 throughout -> flush_d=0 during both stall cycles, flush_d=1 on the release cycle.
- Reset and counters:
  - Assert i_rstn=0 during WAIT -> stall_m=0 immediately, counters 0, FSM in RUN after deassert.
  - i_cnt_clr together with lwstall -> stall_cnt reads 0 next cycle.
